// File: rtl/pps_qualifier_pkg.sv
// Shared types and defaults for the GPS 1PPS qualifier.
// Holds the FSM state encoding and the good-interval counter sizing helper.
package pps_qualifier_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } pps_state_t;

   localparam int DEF_CNTWIDTH   = 27;
   localparam int DEF_MIN_PERIOD = 99_000_000;
   localparam int DEF_MAX_PERIOD = 101_000_000;
   localparam int DEF_LOCK_COUNT = 3;

   // Wide enough to hold the values 0..lock_count inclusive.
   function automatic int good_width(input int lock_count);
      return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
   endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level followed by a rising-edge
// detector; rise is high for exactly one clk cycle per synchronised 0->1 step.
module pulse_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/pps_qualifier.sv
// GPS 1PPS qualifier: synchronises the pulse, checks edge-to-edge intervals
// against a window and strobes once per qualified edge while locked.
// Optional holdover across a single missed pulse: define PPS_QUALIFIER_HOLDOVER_EN.
module pps_qualifier
   import pps_qualifier_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNTWIDTH    = DEF_CNTWIDTH,
   parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter int MAX_PERIOD  = DEF_MAX_PERIOD,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pulse_in,
   input  logic                clear_flags,
   output logic                pulse_strobe,
   output logic                locked,
   output logic                glitch,
   output logic                missing,
   output logic [CNTWIDTH-1:0] period
);

   localparam int                  GW      = good_width(LOCK_COUNT);
   localparam logic [CNTWIDTH-1:0] MIN_C   = CNTWIDTH'(MIN_PERIOD);
   localparam logic [CNTWIDTH-1:0] MAX_C   = CNTWIDTH'(MAX_PERIOD);
   localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);
   localparam logic [GW-1:0]       LOCK_C  = GW'(LOCK_COUNT);
   localparam logic [GW-1:0]       GOOD_ONE = GW'(1);

   pps_state_t          state_q, state_d;
   logic [CNTWIDTH-1:0] cnt_q, cnt_d;
   logic [CNTWIDTH-1:0] period_d;
   logic [GW-1:0]       good_q, good_d;
   logic                strobe_d;
   logic                glitch_set, missing_set;
   logic                rise;
   logic                take_holdover;
   logic [GW-1:0]       good_inc;

   pulse_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pulse_in),
      .rise  (rise)
   );

`ifdef PPS_QUALIFIER_HOLDOVER_EN
   logic hold_q, hold_d;
   // First miss while locked rides through on a synthetic strobe.
   assign take_holdover = (state_q == LOCKED) && !hold_q;
`else
   assign take_holdover = 1'b0;
`endif

   assign good_inc = good_q + GOOD_ONE;
   assign locked   = (state_q == LOCKED);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
      good_d      = good_q;
      period_d    = period;
      strobe_d    = 1'b0;
      glitch_set  = 1'b0;
      missing_set = 1'b0;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
      hold_d      = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = ACQUIRE;
               cnt_d   = CNT_ONE;
               good_d  = '0;
            end
         end
         ACQUIRE, LOCKED: begin
            if (cnt_q > MAX_C) begin
               missing_set = 1'b1;
               if (take_holdover) begin
                  strobe_d = 1'b1;
                  cnt_d    = CNT_ONE;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
                  hold_d   = 1'b1;
`endif
               end else begin
`ifdef PPS_QUALIFIER_HOLDOVER_EN
                  hold_d = 1'b0;
`endif
                  good_d = '0;
                  // A coincident edge restarts acquisition as IDLE's first edge.
                  if (rise) begin
                     state_d = ACQUIRE;
                     cnt_d   = CNT_ONE;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (rise && (cnt_q < MIN_C)) begin
               glitch_set = 1'b1;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
               if (hold_q) begin
                  state_d = IDLE;
                  good_d  = '0;
                  hold_d  = 1'b0;
               end
`endif
            end else if (rise) begin
               period_d = cnt_q;
               cnt_d    = CNT_ONE;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
               hold_d   = 1'b0;
`endif
               if (state_q == ACQUIRE) begin
                  good_d = good_inc;
                  if (good_inc == LOCK_C) begin
                     state_d  = LOCKED;
                     strobe_d = 1'b1;
                  end
               end else begin
                  strobe_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            good_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         good_q       <= '0;
         period       <= '0;
         pulse_strobe <= 1'b0;
         glitch       <= 1'b0;
         missing      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         good_q       <= good_d;
         period       <= period_d;
         pulse_strobe <= strobe_d;
         // Set beats a simultaneous clear.
         glitch       <= glitch_set  | (glitch  & ~clear_flags);
         missing      <= missing_set | (missing & ~clear_flags);
      end
   end

`ifdef PPS_QUALIFIER_HOLDOVER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= 1'b0;
      else        hold_q <= hold_d;
   end
`endif

endmodule
